// File: rtl/ppg_phase_sequencer.sv
// PPG phase sequencer: drives the RED / IR / DARK acquisition frame, applies
// the per-channel front-end settings, averages the ADC per phase and
// publishes ambient-corrected results through a valid/ready handshake.
module ppg_phase_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int AVG_LOG2   = 3
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] RED_PGA,
  input  logic [6:0] RED_DC,
  input  logic [3:0] IR_PGA,
  input  logic [6:0] IR_DC,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [3:0] PGA_Gain,
  output logic [6:0] DC_Comp,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] DARK_ADC_Value,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun
);

  localparam int         ACC_W       = 8 + AVG_LOG2;
  localparam int         ACQ_N       = 1 << AVG_LOG2;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] ACQ_LAST    = 8'(ACQ_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    RED_SETTLE,
    RED_ACQ,
    IR_SETTLE,
    IR_ACQ,
    DARK_SETTLE,
    DARK_ACQ,
    PUBLISH
  } state_t;

  // Ambient subtraction clamps at zero: a channel darker than the dark
  // reading carries no signal.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? 8'd0 : diff[7:0];
  endfunction

  // Averaging is a plain truncating shift of the power-of-two sample sum.
  function automatic logic [7:0] phase_avg(input logic [ACC_W-1:0] sum);
    return 8'(sum >> AVG_LOG2);
  endfunction

  state_t           state, next_state;
  logic [7:0]       cnt, cnt_next;
  logic             in_acq, acq_last, start_frame;
  logic [ACC_W-1:0] acc_p0, acc_sum;
  logic [7:0]       red_avg_p1, ir_avg_p1, dark_avg_p1;
  logic [3:0]       lat_red_pga, lat_ir_pga;
  logic [6:0]       lat_red_dc, lat_ir_dc;

  // Next-state and phase-counter logic; a dropped enable aborts to IDLE.
  always_comb begin
    next_state = state;
    cnt_next   = cnt + 8'd1;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (enable) next_state = RED_SETTLE;
      end
      RED_SETTLE:  if (cnt == SETTLE_LAST) begin next_state = RED_ACQ;     cnt_next = '0; end
      RED_ACQ:     if (cnt == ACQ_LAST)    begin next_state = IR_SETTLE;   cnt_next = '0; end
      IR_SETTLE:   if (cnt == SETTLE_LAST) begin next_state = IR_ACQ;      cnt_next = '0; end
      IR_ACQ:      if (cnt == ACQ_LAST)    begin next_state = DARK_SETTLE; cnt_next = '0; end
      DARK_SETTLE: if (cnt == SETTLE_LAST) begin next_state = DARK_ACQ;    cnt_next = '0; end
      DARK_ACQ:    if (cnt == ACQ_LAST)    begin next_state = PUBLISH;     cnt_next = '0; end
      PUBLISH: begin
        cnt_next   = '0;
        next_state = enable ? RED_SETTLE : IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (state != IDLE && !enable) begin
      next_state = IDLE;
      cnt_next   = '0;
    end
  end

  // Phase decode shared by the accumulator and settings latch.
  always_comb begin
    in_acq      = (state == RED_ACQ) || (state == IR_ACQ) || (state == DARK_ACQ);
    acq_last    = in_acq && (cnt == ACQ_LAST);
    start_frame = (next_state == RED_SETTLE) && ((state == IDLE) || (state == PUBLISH));
    acc_sum     = acc_p0 + ACC_W'(ADC);
  end

  // State register and in-phase cycle counter.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Channel settings are captured once per frame so mid-frame edits wait.
  always_ff @(posedge CLK) begin
    if (rst) begin
      lat_red_pga <= '0;
      lat_red_dc  <= '0;
      lat_ir_pga  <= '0;
      lat_ir_dc   <= '0;
    end else if (start_frame) begin
      lat_red_pga <= RED_PGA;
      lat_red_dc  <= RED_DC;
      lat_ir_pga  <= IR_PGA;
      lat_ir_dc   <= IR_DC;
    end
  end

  // Sample accumulation: runs only in ACQ states, held at zero elsewhere so
  // every ACQ state starts from a clean sum.
  always_ff @(posedge CLK) begin
    if (rst || !in_acq) acc_p0 <= '0;
    else                acc_p0 <= acc_sum;
  end

  // Phase averages: captured with the final sample of each completed ACQ.
  always_ff @(posedge CLK) begin
    if (rst) begin
      red_avg_p1  <= '0;
      ir_avg_p1   <= '0;
      dark_avg_p1 <= '0;
    end else if (acq_last && enable) begin
      case (state)
        RED_ACQ:  red_avg_p1  <= phase_avg(acc_sum);
        IR_ACQ:   ir_avg_p1   <= phase_avg(acc_sum);
        DARK_ACQ: dark_avg_p1 <= phase_avg(acc_sum);
        default:  ;
      endcase
    end
  end

  // Registered front-end drive, results and handshake.
  always_ff @(posedge CLK) begin
    if (rst) begin
      LED_RED        <= 1'b0;
      LED_IR         <= 1'b0;
      PGA_Gain       <= '0;
      DC_Comp        <= 7'd127;
      RED_ADC_Value  <= '0;
      IR_ADC_Value   <= '0;
      DARK_ADC_Value <= '0;
      frame_valid    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      LED_RED <= (state == RED_SETTLE) || (state == RED_ACQ);
      LED_IR  <= (state == IR_SETTLE) || (state == IR_ACQ);
      case (state)
        IDLE: begin
          PGA_Gain <= '0;
          DC_Comp  <= 7'd127;
        end
        IR_SETTLE, IR_ACQ: begin
          PGA_Gain <= lat_ir_pga;
          DC_Comp  <= lat_ir_dc;
        end
        default: begin
          PGA_Gain <= lat_red_pga;
          DC_Comp  <= lat_red_dc;
        end
      endcase
      if (state == PUBLISH) begin
        RED_ADC_Value  <= sat_sub(red_avg_p1, dark_avg_p1);
        IR_ADC_Value   <= sat_sub(ir_avg_p1, dark_avg_p1);
        DARK_ADC_Value <= dark_avg_p1;
        frame_valid    <= 1'b1;
        if (frame_valid && !frame_ready)     overrun <= 1'b1;
        else if (frame_valid && frame_ready) overrun <= 1'b0;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppg_phase_sequencer.sv
// Bench for ppg_phase_sequencer: directed frames checked against a
// frame-position model every cycle plus hand-computed expectations.
module tb_ppg_phase_sequencer;

  localparam int SETTLE_CYC = 4;
  localparam int AVG_LOG2   = 3;
  localparam int S    = SETTLE_CYC;
  localparam int N    = 1 << AVG_LOG2;
  localparam int P    = S + N;
  localparam int FLEN = 3 * P + 1;

  logic       CLK = 1'b0;
  logic       rst, enable, frame_ready;
  logic [3:0] RED_PGA, IR_PGA;
  logic [6:0] RED_DC, IR_DC;
  logic [7:0] ADC;
  logic       LED_RED, LED_IR, frame_valid, overrun;
  logic [3:0] PGA_Gain;
  logic [6:0] DC_Comp;
  logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;

  ppg_phase_sequencer #(.SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)) dut (
    .CLK(CLK), .rst(rst), .enable(enable),
    .RED_PGA(RED_PGA), .RED_DC(RED_DC), .IR_PGA(IR_PGA), .IR_DC(IR_DC),
    .ADC(ADC), .LED_RED(LED_RED), .LED_IR(LED_IR),
    .PGA_Gain(PGA_Gain), .DC_Comp(DC_Comp),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .DARK_ADC_Value(DARK_ADC_Value),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0, cyc = 0;
  bit chk_en = 0;
  int start_cyc = 0, rise_cyc = 0, rise_cnt = 0;
  logic fv_q = 1'b0;

  logic       s_lr [FLEN], s_li [FLEN], s_fv [FLEN], s_ov [FLEN];
  logic [7:0] s_pga [FLEN], s_dc [FLEN], s_red [FLEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: tracks position within the frame and derives outputs from it.
  bit m_run = 0;
  int m_t = 0;
  int m_rp = 0, m_rd = 0, m_ip = 0, m_id = 0;
  int m_sum [3], m_avg [3];
  bit e_lr = 0, e_li = 0, e_fv = 0, e_ov = 0;
  int e_pga = 0, e_dc = 127, e_red = 0, e_ir = 0, e_dark = 0;

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    int ph, w;
    bit pub;
    if (rst) begin
      m_run = 0; m_t = 0;
      e_lr = 0; e_li = 0; e_pga = 0; e_dc = 127;
      e_red = 0; e_ir = 0; e_dark = 0; e_fv = 0; e_ov = 0;
      for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_avg[k] = 0; end
    end else begin
      ph  = m_t / P;
      w   = m_t % P;
      pub = m_run && (ph == 3);
      if (!m_run) begin
        e_lr = 0; e_li = 0; e_pga = 0; e_dc = 127;
      end else begin
        e_lr  = (ph == 0);
        e_li  = (ph == 1);
        e_pga = (ph == 1) ? m_ip : m_rp;
        e_dc  = (ph == 1) ? m_id : m_rd;
      end
      if (pub) begin
        e_red  = (m_avg[0] > m_avg[2]) ? m_avg[0] - m_avg[2] : 0;
        e_ir   = (m_avg[1] > m_avg[2]) ? m_avg[1] - m_avg[2] : 0;
        e_dark = m_avg[2];
        if (e_fv && !frame_ready)     e_ov = 1;
        else if (e_fv && frame_ready) e_ov = 0;
        e_fv = 1;
      end else if (e_fv && frame_ready) begin
        e_fv = 0; e_ov = 0;
      end
      if (m_run && enable && !pub && w >= S) begin
        m_sum[ph] += int'(ADC);
        if (w == P - 1) begin
          m_avg[ph] = m_sum[ph] / N;
          m_sum[ph] = 0;
        end
      end
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_t = 0;
          m_rp = int'(RED_PGA); m_rd = int'(RED_DC); m_ip = int'(IR_PGA); m_id = int'(IR_DC);
        end
      end else if (!enable) begin
        m_run = 0;
        for (int k = 0; k < 3; k++) m_sum[k] = 0;
      end else if (pub) begin
        m_t = 0;
        m_rp = int'(RED_PGA); m_rd = int'(RED_DC); m_ip = int'(IR_PGA); m_id = int'(IR_DC);
      end else begin
        m_t++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("LED_RED", 32'(LED_RED), 32'(e_lr));
      check("LED_IR", 32'(LED_IR), 32'(e_li));
      check("PGA_Gain", 32'(PGA_Gain), 32'(e_pga));
      check("DC_Comp", 32'(DC_Comp), 32'(e_dc));
      check("RED_ADC_Value", 32'(RED_ADC_Value), 32'(e_red));
      check("IR_ADC_Value", 32'(IR_ADC_Value), 32'(e_ir));
      check("DARK_ADC_Value", 32'(DARK_ADC_Value), 32'(e_dark));
      check("frame_valid", 32'(frame_valid), 32'(e_fv));
      check("overrun", 32'(overrun), 32'(e_ov));
    end
  end

  // frame_valid rising-edge monitor.
  always @(negedge CLK) begin
    if (frame_valid === 1'b1 && fv_q !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    fv_q = frame_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one frame's ADC pattern; t is the cycle index after the start edge.
  task automatic run_frame(input int rv, input int iv, input int dv, input bit ramp,
                           input int settle_v, input int stop_t, input int rst_t,
                           input bit scramble);
    int ph, w;
    for (int t = 0; t < FLEN; t++) begin
      @(negedge CLK);
      if (t == 0) start_cyc = cyc;
      s_lr[t] = LED_RED;  s_li[t] = LED_IR;  s_fv[t] = frame_valid; s_ov[t] = overrun;
      s_pga[t] = 8'(PGA_Gain); s_dc[t] = 8'(DC_Comp); s_red[t] = RED_ADC_Value;
      ph = t / P;
      w  = t % P;
      if (ph == 3)                              ADC = 8'd0;
      else if (ramp && ph == 0 && w >= S)       ADC = 8'(w - S);
      else if (w < S && settle_v >= 0)          ADC = 8'(settle_v);
      else                                      ADC = 8'((ph == 0) ? rv : (ph == 1) ? iv : dv);
      if (scramble && t == 10) begin
        RED_PGA = 4'($urandom); RED_DC = 7'($urandom);
        IR_PGA  = 4'($urandom); IR_DC  = 7'($urandom);
      end
      if (t == rst_t) begin
        rst = 1'b1; enable = 1'b0;
        @(negedge CLK);
        rst = 1'b0;
        return;
      end
      if (t == stop_t) begin
        enable = 1'b0;
        if (t != FLEN - 1) return;
      end
    end
  endtask

  initial begin
    int r0;
    rst = 1'b1; enable = 1'b0; frame_ready = 1'b0; ADC = 8'd0;
    RED_PGA = 4'd0; RED_DC = 7'd0; IR_PGA = 4'd0; IR_DC = 7'd0;
    repeat (2) @(negedge CLK);
    chk_en = 1;
    check("rst_led_red", 32'(LED_RED), 32'd0);
    check("rst_led_ir", 32'(LED_IR), 32'd0);
    check("rst_pga", 32'(PGA_Gain), 32'd0);
    check("rst_dc", 32'(DC_Comp), 32'd127);
    check("rst_results", 32'({RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}), 32'd0);
    check("rst_fv_ov", 32'({frame_valid, overrun}), 32'd0);
    rst = 1'b0;

    // Nominal frame.
    RED_PGA = 4'd5; RED_DC = 7'd40; IR_PGA = 4'd9; IR_DC = 7'd60;
    frame_ready = 1'b1; enable = 1'b1;
    run_frame(200, 150, 20, 0, -1, FLEN - 1, -1, 0);
    @(negedge CLK); #1;
    check("t1_latency", 32'(rise_cyc - start_cyc), 32'd37);
    check("t1_fv", 32'(frame_valid), 32'd1);
    check("t1_red", 32'(RED_ADC_Value), 32'd180);
    check("t1_ir", 32'(IR_ADC_Value), 32'd130);
    check("t1_dark", 32'(DARK_ADC_Value), 32'd20);
    check("t1_idle_pga_dc", 32'({s_pga[0], s_dc[0]}), 32'({8'd0, 8'd127}));
    check("t1_red_pga_dc", 32'({s_pga[6], s_dc[6]}), 32'({8'd5, 8'd40}));
    check("t1_ir_pga_dc", 32'({s_pga[20], s_dc[20]}), 32'({8'd9, 8'd60}));
    check("t1_dark_pga_dc", 32'({s_pga[30], s_dc[30]}), 32'({8'd5, 8'd40}));
    check("t1_leds_red", 32'({s_lr[6], s_li[6]}), 32'd2);
    check("t1_leds_ir", 32'({s_lr[20], s_li[20]}), 32'd1);
    check("t1_leds_dark", 32'({s_lr[30], s_li[30]}), 32'd0);

    // Saturation, with settings scrambled mid-frame.
    repeat (3) @(negedge CLK);
    enable = 1'b1;
    run_frame(10, 50, 30, 0, -1, FLEN - 1, -1, 1);
    @(negedge CLK);
    check("t2_red_sat", 32'(RED_ADC_Value), 32'd0);
    check("t2_ir", 32'(IR_ADC_Value), 32'd20);
    check("t2_dark", 32'(DARK_ADC_Value), 32'd30);
    check("t2_ir_pga_held", 32'({s_pga[20], s_dc[20]}), 32'({8'd9, 8'd60}));

    // Truncating average, settle samples ignored.
    repeat (3) @(negedge CLK);
    enable = 1'b1;
    run_frame(0, 100, 0, 1, 255, FLEN - 1, -1, 0);
    @(negedge CLK);
    check("t3_red_trunc", 32'(RED_ADC_Value), 32'd3);
    check("t3_ir", 32'(IR_ADC_Value), 32'd100);
    check("t3_dark", 32'(DARK_ADC_Value), 32'd0);

    // Overrun across two unaccepted frames.
    repeat (3) @(negedge CLK);
    frame_ready = 1'b0; enable = 1'b1;
    run_frame(100, 80, 10, 0, -1, -1, -1, 0);
    run_frame(60, 50, 5, 0, -1, FLEN - 1, -1, 0);
    check("t4_first_fv", 32'(s_fv[0]), 32'd1);
    check("t4_first_red", 32'(s_red[0]), 32'd90);
    check("t4_first_ov", 32'(s_ov[0]), 32'd0);
    @(negedge CLK);
    check("t4_second_fv", 32'(frame_valid), 32'd1);
    check("t4_second_ov", 32'(overrun), 32'd1);
    check("t4_second_vals", 32'({RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}),
          32'({8'd55, 8'd45, 8'd5}));
    frame_ready = 1'b1;
    @(negedge CLK);
    check("t4_accept_fv_ov", 32'({frame_valid, overrun}), 32'd0);

    // Abort during IR_ACQ, restart after 5 cycles.
    repeat (2) @(negedge CLK);
    r0 = rise_cnt;
    enable = 1'b1;
    run_frame(50, 40, 10, 0, -1, 18, -1, 0);
    repeat (5) @(negedge CLK);
    check("t5_idle_leds", 32'({LED_RED, LED_IR}), 32'd0);
    check("t5_idle_fv", 32'(frame_valid), 32'd0);
    check("t5_idle_pga_dc", 32'({4'd0, PGA_Gain, 1'b0, DC_Comp}), 32'({8'd0, 8'd127}));
    enable = 1'b1;
    run_frame(70, 60, 10, 0, -1, FLEN - 1, -1, 0);
    @(negedge CLK); #1;
    check("t5_one_frame_only", 32'(rise_cnt - r0), 32'd1);
    check("t5_latency", 32'(rise_cyc - start_cyc), 32'd37);
    check("t5_vals", 32'({RED_ADC_Value, IR_ADC_Value}), 32'({8'd60, 8'd50}));

    // Reset pulse in DARK_ACQ while a frame is pending.
    frame_ready = 1'b0;
    repeat (2) @(negedge CLK);
    enable = 1'b1;
    run_frame(120, 90, 30, 0, -1, FLEN - 1, -1, 0);
    @(negedge CLK);
    check("t6_pending_fv", 32'(frame_valid), 32'd1);
    check("t6_pending_red", 32'(RED_ADC_Value), 32'd90);
    enable = 1'b1;
    run_frame(0, 0, 0, 0, -1, -1, 30, 0);
    check("t6_fv_before_rst", 32'(s_fv[29]), 32'd1);
    check("t6_rst_leds", 32'({LED_RED, LED_IR}), 32'd0);
    check("t6_rst_pga_dc", 32'({4'd0, PGA_Gain, 1'b0, DC_Comp}), 32'({8'd0, 8'd127}));
    check("t6_rst_results", 32'({RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}), 32'd0);
    check("t6_rst_fv_ov", 32'({frame_valid, overrun}), 32'd0);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ppg_phase_sequencer.md
PPG_PHASE_SEQUENCER -- requirements
Module: ppg_phase_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4, giving the LED/analog settling cycles per phase (range 1..255).
REQ-002 The block SHALL have parameter AVG_LOG2, default 3, where 2^AVG_LOG2 is the number of ADC samples averaged per phase (range 0..4).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit; when high, the block runs frames continuously.
REQ-006 The block SHALL have ports RED_PGA, input, 4 bits, and RED_DC, input, 7 bits, carrying the RED channel gain and DC-compensation settings.
REQ-007 The block SHALL have ports IR_PGA, input, 4 bits, and IR_DC, input, 7 bits, carrying the IR channel gain and DC-compensation settings.
REQ-008 The block SHALL have port ADC, input, 8 bits, the conditioned photodiode sample, valid every cycle.
REQ-009 The block SHALL have ports LED_RED and LED_IR, output, 1 bit each, the LED enables.
REQ-010 The block SHALL have ports PGA_Gain, output, 4 bits, and DC_Comp, output, 7 bits, the front-end settings currently applied.
REQ-011 The block SHALL have ports RED_ADC_Value, IR_ADC_Value and DARK_ADC_Value, output, 8 bits each, the per-frame results.
REQ-012 The block SHALL have ports frame_valid (output, 1), frame_ready (input, 1) and overrun (output, 1), forming the result handshake and the lost-frame flag.

Function
REQ-013 The block SHALL implement the states IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, DARK_SETTLE, DARK_ACQ and PUBLISH.
REQ-014 On the IDLE to RED_SETTLE transition, taken when enable=1, the block SHALL latch RED_PGA, RED_DC, IR_PGA and IR_DC; changes to these inputs mid-frame SHALL have no effect until the next latch.
REQ-015 Each SETTLE state SHALL last exactly SETTLE_CYC cycles, and each ACQ state exactly 2^AVG_LOG2 cycles; the states SHALL run in the order RED, IR, DARK, then PUBLISH for 1 cycle.
REQ-016 From PUBLISH, the block SHALL go to RED_SETTLE and re-latch the settings if enable=1, otherwise to IDLE; the frame length SHALL be 3*(SETTLE_CYC+2^AVG_LOG2)+1 cycles (37 with default parameters).
REQ-017 All outputs SHALL be registered, so each output reflects the current state one cycle after that state is entered.
REQ-018 LED_RED SHALL be 1 only during RED_SETTLE and RED_ACQ, and LED_IR SHALL be 1 only during IR_SETTLE and IR_ACQ; both LEDs SHALL never be 1 simultaneously.
REQ-019 PGA_Gain and DC_Comp SHALL take the latched RED values during RED and DARK phases, the latched IR values during IR phases, and 0 and 127 respectively in IDLE.
REQ-020 The block SHALL add ADC into a (8+AVG_LOG2)-bit accumulator on every ACQ cycle, clear it on entry to each ACQ state, and ignore ADC during SETTLE states.
REQ-021 The phase average SHALL be the accumulator, including the final sample, shifted right by AVG_LOG2 (truncating), and SHALL be stored in an internal per-phase register at the end of its ACQ state.
REQ-022 In PUBLISH, the block SHALL compute RED_ADC_Value = max(red_avg - dark_avg, 0), IR_ADC_Value = max(ir_avg - dark_avg, 0) and DARK_ADC_Value = dark_avg, and set frame_valid=1.
REQ-023 frame_valid SHALL remain 1 and the result outputs SHALL remain stable until a cycle with frame_ready=1, after which frame_valid SHALL be 0 in the next cycle.
REQ-024 If PUBLISH occurs while frame_valid=1 and frame_ready=0, the block SHALL overwrite the results with the new frame, keep frame_valid=1 and set overrun=1.
REQ-025 If PUBLISH coincides with a frame_ready=1 accept, the new frame SHALL be presented and overrun SHALL NOT be set.
REQ-026 overrun SHALL be sticky and SHALL clear only on rst or on a handshake (frame_valid=1 and frame_ready=1).
REQ-027 If enable falls during any non-IDLE state, the block SHALL enter IDLE on the next edge, turn both LEDs off, discard the partial frame, and leave frame_valid and the results unchanged.

Reset
REQ-028 While rst=1, the block SHALL enter IDLE and set LED_RED=0, LED_IR=0, PGA_Gain=0, DC_Comp=127, all result outputs=0, frame_valid=0, overrun=0, and clear all counters and accumulators.
REQ-029 rst SHALL take priority over enable and frame_ready, and a rst asserted mid-frame SHALL discard all partial data.

Verification
REQ-030 With default parameters, enable=1, RED_PGA=5, RED_DC=40, IR_PGA=9, IR_DC=60 and ADC=200 during RED, 150 during IR, 20 during DARK, and frame_ready=1, the bench SHALL check frame_valid rising 37 cycles after the start with RED=180, IR=130, DARK=20, and PGA_Gain/DC_Comp showing 5/40 then 9/60 then 5/40.
REQ-031 With ADC=10 during RED and 30 during DARK, the bench SHALL check RED_ADC_Value=0 (saturation) and DARK_ADC_Value=30.
REQ-032 With ADC ramping 0..7 during RED_ACQ (AVG_LOG2=3) and 0 during DARK, the bench SHALL check RED_ADC_Value=3 (truncating 28/8) and that samples taken during the settle cycles have no effect.
REQ-033 With frame_ready held at 0 across two frames, the bench SHALL check that the second frame's values replace the first, frame_valid stays 1 and overrun=1, and that a single frame_ready=1 cycle clears both.
REQ-034 With enable dropped during IR_ACQ and restored 5 cycles later, the bench SHALL check that both LEDs are 0 in IDLE, no frame_valid is produced for the aborted frame, and the next frame takes the full 37 cycles.
REQ-035 With rst pulsed for 1 cycle during DARK_ACQ while frame_valid=1, the bench SHALL check that all outputs match REQ-028 on the following cycle.
